// File: rtl/brick_map.sv
// brick_map: damage state for the 5x5 brick field plus the per-pixel
// colour lookup used by the VGA scan path.
//  - Hit strobes from the ball block raise a brick's damage monotonically.
//  - A brick reaching damage 3 is destroyed: the live count drops and a
//    one-cycle pulse fires.
//  - Pixel queries go through a 2-stage pipeline.
//    Stage 1 decodes row/col with comparators only.
//    Stage 2 looks up damage and registers the colour.
module brick_map #(
  parameter int          NUM_BLOCKS      = 25,
  parameter int          BLOCK_WIDTH     = 80,
  parameter int          BLOCK_HEIGHT    = 30,
  parameter int          BLOCK_SPACING_X = 40,
  parameter int          FIRST_ROW_Y     = 40,
  parameter int          ROW_PITCH       = 50,
  parameter logic [7:0]  COLOR_FRESH     = 8'hE0,
  parameter logic [7:0]  COLOR_HIT1      = 8'hF0,
  parameter logic [7:0]  COLOR_HIT2      = 8'hFC,
  parameter logic [7:0]  COLOR_BG        = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       erase_enable,
  input  logic [5:0] e_pos,
  input  logic [1:0] active_data,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       video_on,
  output logic [7:0] rgb,
  output logic       brick_hit,
  output logic [4:0] bricks_left,
  output logic       destroyed_pulse,
  output logic       all_clear
);

  localparam int NUM_ROWS  = 5;
  localparam int NUM_COLS  = 5;
  // Horizontal pitch: the brick plus the gap that follows it.
  localparam int COL_PITCH = BLOCK_WIDTH + BLOCK_SPACING_X;

  // ---------------------------------------------------------------------
  // Brick state
  // ---------------------------------------------------------------------
  logic [NUM_BLOCKS-1:0][1:0] r_damage;
  logic [4:0]                 r_left;
  logic                       r_pulse;
  logic                       r_all_clear;

  logic       w_pos_ok;
  logic       w_hit_ok;
  logic [1:0] w_cur;
  logic       w_raise;
  logic       w_destroy;
  logic [4:0] w_left_nxt;

  // Current damage of the addressed brick.
  // The loop compare keeps out-of-range indices from reading past the array.
  always_comb begin
    w_cur = 2'd0;
    for (int i = 0; i < NUM_BLOCKS; i++)
      if (e_pos == 6'(i)) w_cur = r_damage[i];
  end

  // Classify the incoming hit.
  // Only a strictly higher value moves the brick; reaching 3 destroys it.
  always_comb begin
    w_pos_ok   = (e_pos < 6'(NUM_BLOCKS));
    w_hit_ok   = erase_enable && w_pos_ok && (active_data != 2'd0);
    w_raise    = w_hit_ok && (active_data > w_cur);
    w_destroy  = w_raise && (active_data == 2'd3);
    w_left_nxt = r_left;
    if (w_destroy && (r_left != 5'd0)) w_left_nxt = r_left - 5'd1;
  end

  // Damage array update.
  // Reset wins over a same-cycle hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_damage <= '0;
    end else begin
      for (int i = 0; i < NUM_BLOCKS; i++)
        if (w_raise && (e_pos == 6'(i))) r_damage[i] <= active_data;
    end
  end

  // Live-brick count, destroy pulse and cleared-field flag.
  // all_clear tracks the next count so it lines up with bricks_left.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_left      <= 5'(NUM_BLOCKS);
      r_pulse     <= 1'b0;
      r_all_clear <= 1'b0;
    end else begin
      r_left      <= w_left_nxt;
      r_pulse     <= w_destroy;
      r_all_clear <= (w_left_nxt == 5'd0);
    end
  end

  assign bricks_left     = r_left;
  assign destroyed_pulse = r_pulse;
  assign all_clear       = r_all_clear;

  // ---------------------------------------------------------------------
  // Pixel pipeline, stage 1: row/col decode
  // ---------------------------------------------------------------------
  logic [NUM_ROWS-1:0] w_row_in;
  logic [NUM_COLS-1:0] w_col_in;
  logic [2:0]          w_row;
  logic [2:0]          w_col;
  logic                w_row_vld;
  logic                w_col_vld;

  // One range compare per row/column.
  // Edges are inclusive top/left and exclusive bottom/right.
  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    assign w_row_in[r] = (pixel_y >= 10'(FIRST_ROW_Y + ROW_PITCH*r)) &&
                         (pixel_y <  10'(FIRST_ROW_Y + ROW_PITCH*r + BLOCK_HEIGHT));
  end
  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    assign w_col_in[c] = (pixel_x >= 10'(BLOCK_SPACING_X + COL_PITCH*c)) &&
                         (pixel_x <  10'(BLOCK_SPACING_X + COL_PITCH*c + BLOCK_WIDTH));
  end

  // Encode the one-hot range hits into indices.
  // The ranges are disjoint, so at most one bit is ever set.
  always_comb begin
    w_row     = 3'd0;
    w_row_vld = 1'b0;
    w_col     = 3'd0;
    w_col_vld = 1'b0;
    for (int i = 0; i < NUM_ROWS; i++)
      if (w_row_in[i]) begin
        w_row     = 3'(i);
        w_row_vld = 1'b1;
      end
    for (int i = 0; i < NUM_COLS; i++)
      if (w_col_in[i]) begin
        w_col     = 3'(i);
        w_col_vld = 1'b1;
      end
  end

  logic [2:0] r_row;
  logic [2:0] r_col;
  logic       r_row_vld;
  logic       r_col_vld;
  logic       r_von;

  // Stage 1 registers.
  // Clearing them on reset blanks the pixel already in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_row     <= 3'd0;
      r_col     <= 3'd0;
      r_row_vld <= 1'b0;
      r_col_vld <= 1'b0;
      r_von     <= 1'b0;
    end else begin
      r_row     <= w_row;
      r_col     <= w_col;
      r_row_vld <= w_row_vld;
      r_col_vld <= w_col_vld;
      r_von     <= video_on;
    end
  end

  // ---------------------------------------------------------------------
  // Pixel pipeline, stage 2: damage lookup and colour
  // ---------------------------------------------------------------------
  logic [5:0] w_idx;
  logic [1:0] w_d;
  logic       w_live;
  logic [7:0] w_color;

  // 5*row + col, as row*4 + row + col.
  assign w_idx = {1'b0, r_row, 2'b00} + {3'b000, r_row} + {3'b000, r_col};

  // Look up the damage of the indexed brick.
  // An unmatched index defaults to destroyed, which draws background.
  always_comb begin
    w_d = 2'd3;
    for (int i = 0; i < NUM_BLOCKS; i++)
      if (w_idx == 6'(i)) w_d = r_damage[i];
  end

  // Decide whether the pixel shows a live brick, and pick its colour.
  always_comb begin
    w_live = r_row_vld && r_col_vld && r_von && (w_d != 2'd3);
    unique case (w_d)
      2'd0:    w_color = COLOR_FRESH;
      2'd1:    w_color = COLOR_HIT1;
      2'd2:    w_color = COLOR_HIT2;
      default: w_color = COLOR_BG;
    endcase
    if (!w_live) w_color = COLOR_BG;
  end

  logic [7:0] r_rgb;
  logic       r_brick_hit;

  // Stage 2 registers.
  // They drive the colour and brick flag together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rgb       <= COLOR_BG;
      r_brick_hit <= 1'b0;
    end else begin
      r_rgb       <= w_color;
      r_brick_hit <= w_live;
    end
  end

  assign rgb       = r_rgb;
  assign brick_hit = r_brick_hit;

endmodule

// File: doc/brick_map.md
Name: brick_map

Overview:
- Receiving end of the ball block's brick-hit interface (`erase_enable`, `e_pos`, `active_data`).
- Holds the damage state of all 25 bricks in the 5x5 field, counts destroyed bricks and flags the cleared field.
- Answers per-pixel queries from the VGA scan path with a registered brick colour, so bricks are drawn from the same hit events the ball logic produces.

Parameters:
- `NUM_BLOCKS`, 25, number of bricks (5 rows x 5 columns).
- `BLOCK_WIDTH`, 80, brick width in pixels.
- `BLOCK_HEIGHT`, 30, brick height in pixels.
- `BLOCK_SPACING_X`, 40, left margin and horizontal gap between bricks.
- `FIRST_ROW_Y`, 40, top of row 0; row r top = `FIRST_ROW_Y` + 50*r.
- `ROW_PITCH`, 50, vertical distance between row tops.
- `COLOR_FRESH`, 8'hE0, RGB332 colour for damage 0.
- `COLOR_HIT1`, 8'hF0, colour for damage 1.
- `COLOR_HIT2`, 8'hFC, colour for damage 2.
- `COLOR_BG`, 8'h00, colour outside bricks or for destroyed bricks.

Ports:
- `clk`  in  1  game/pixel clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `erase_enable`  in  1  one-cycle hit strobe from the ball block.
- `e_pos`  in  6  brick index 0..24 of the hit; row = `e_pos`/5, col = `e_pos`%5.
- `active_data`  in  2  new hit count of that brick, 1..3; 3 = destroyed.
- `pixel_x`  in  10  current scan column 0..639.
- `pixel_y`  in  10  current scan row 0..479.
- `video_on`  in  1  high inside the visible area.
- `rgb`  out  8  brick colour for the queried pixel; 2-cycle latency.
- `brick_hit`  out  1  registered pixel-is-inside-a-live-brick flag, aligned with `rgb`.
- `bricks_left`  out  5  count of bricks with damage < 3.
- `destroyed_pulse`  out  1  one-cycle pulse when a brick reaches damage 3.
- `all_clear`  out  1  high while `bricks_left` == 0.

Behaviour:
- State: `damage[0..24]`, 2 bits each.
- Reset values: all `damage` = 0, `bricks_left` = 25, `rgb` = `COLOR_BG`, `brick_hit` = 0, `destroyed_pulse` = 0, `all_clear` = 0, pipeline registers cleared.
- Reset has priority over any same-cycle `erase_enable`. Reset mid-frame forces background output for 2 cycles.
- Hit update, on `erase_enable` = 1:
  - Ignore if `e_pos` >= `NUM_BLOCKS` or `active_data` == 0.
  - Otherwise `damage[e_pos]` <= max(`damage[e_pos]`, `active_data`). Damage is monotonic; a lower or equal value is ignored.
- Destroy: if the update moves `damage` from <3 to 3, `bricks_left` decrements by 1 and `destroyed_pulse` = 1 on the next cycle. A repeat hit on a destroyed brick does neither.
  - `bricks_left` saturates at 0, never wraps.
- `all_clear` is registered, = (`bricks_left` == 0). It stays high until reset.
- Pixel pipeline, stage 1:
  - Register row index = r where `FIRST_ROW_Y` + 50r <= `pixel_y` < that + `BLOCK_HEIGHT`, plus a row-valid bit.
  - Register col index = c where 40 + 120c <= `pixel_x` < that + `BLOCK_WIDTH`, plus a col-valid bit.
  - Register `video_on`.
  - Decode uses comparators only, no dividers. Edges are inclusive left/top and exclusive right/bottom.
- Pixel pipeline, stage 2: index = 5*row + col; d = `damage[index]`.
  - If row-valid, col-valid, registered `video_on` and d < 3: `rgb` = colour for d, `brick_hit` = 1.
  - Otherwise `rgb` = `COLOR_BG`, `brick_hit` = 0.
  - Stage 2 reads `damage` after any same-cycle update is registered, i.e. a hit becomes visible on the pixel entering stage 2 the cycle after the write.
- Gaps:
  - X 0..39, 120..159, 240..279, 360..399, 480..519 and 600..639 are background.
  - Y < 40, 70..89, 120..139, 170..189, 220..239 and >= 270 are background.
- Arithmetic is unsigned 10-bit; 5*row+col is computed in 6 bits.

Test Plan:
- Reset, then scan (40,40) and (119,69) -> `rgb` 8'hE0 two cycles later with `brick_hit` = 1; (120,40) and (40,70) -> 8'h00. Reset state: `bricks_left` = 25, `all_clear` = 0.
- `erase_enable` with `e_pos` = 7, `active_data` = 1, then 2, then 3 -> pixel (300,100) shows E0 -> F0 -> FC -> 00. `destroyed_pulse` fires once, `bricks_left` = 24.
- Repeat `e_pos` = 7 with `active_data` = 3, then `active_data` = 1 -> no pulse, `bricks_left` stays 24, `damage` stays 3.
- `e_pos` = 25 and 63 with `active_data` = 3, plus `active_data` = 0 on `e_pos` = 0 -> no state change, no pulse.
- Destroy all 25 bricks back-to-back on consecutive cycles -> 25 pulses, `bricks_left` = 0, `all_clear` = 1. A further hit does not wrap the count.
- `reset` asserted in the same cycle as `erase_enable` (`e_pos` = 3, `active_data` = 3) -> brick 3 stays at damage 0, `bricks_left` = 25. Scan with `video_on` = 0 inside a brick -> `rgb` 8'h00.
